// File: rtl/bpb_pkg.sv
// Shared types and constants for the 2-way branch prediction buffer.
// Confidence counters exist only when BPB_COUNTER_EN is defined.
package bpb_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_INIT = 2'b10;
   localparam ctr_t CTR_MAX  = 2'b11;
   localparam ctr_t CTR_MIN  = 2'b00;

   // Tags are stored zero-extended to this width so the struct stays fixed-size.
   localparam int unsigned MAX_TAG_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic [31:0]          target;
      ctr_t                 ctr;
   } entry_t;

   function automatic int unsigned sets_of(input int unsigned entries);
      return entries / 2;
   endfunction

   function automatic int unsigned idx_w_of(input int unsigned entries);
      return $clog2(entries / 2);
   endfunction

endpackage

// File: rtl/bpb_table_if.sv
// Controller/fetch-facing signal bundle of the branch prediction buffer.
// The table takes the slave side; the controller and fetch drive the master side.
interface bpb_table_if #(
   parameter int unsigned TAG_WIDTH = 30
);
   logic                 stall;
   logic [TAG_WIDTH-1:0] lookup_tag;
   logic                 hit;
   logic [31:0]          pred_addr;
   logic                 w_en;
   logic                 sw;
   logic                 set_valid;
   logic [TAG_WIDTH-1:0] set_tag;
   logic [31:0]          set_addr;
   logic [31:0]          check_addr;
   logic                 conflict;

   modport master (
      output stall, lookup_tag, w_en, sw, set_valid, set_tag, set_addr, check_addr,
      input  hit, pred_addr, conflict
   );

   modport slave (
      input  stall, lookup_tag, w_en, sw, set_valid, set_tag, set_addr, check_addr,
      output hit, pred_addr, conflict
   );
endinterface

// File: rtl/bpb_sat_counter.sv
// 2-bit saturating up/down counter step used for branch confidence.
module bpb_sat_counter
   import bpb_pkg::*;
(
   input  ctr_t ctr,
   input  logic up,
   output ctr_t ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (up) begin
         if (ctr != CTR_MAX) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_MIN) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/bpb_table.sv
// 2-way set-associative branch prediction buffer storage with per-set LRU.
// Define BPB_COUNTER_EN to add 2-bit confidence counters gating the hit output.
module bpb_table
   import bpb_pkg::*;
#(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned TAG_WIDTH = 30
) (
   input logic        clk,
   input logic        resetn,
   bpb_table_if.slave bus
);

   localparam int unsigned SETS  = sets_of(ENTRIES);
   localparam int unsigned IDX_W = idx_w_of(ENTRIES);

   entry_t            tbl_q [2][SETS];
   logic   [SETS-1:0] lru_q;

   // Fetch-side lookup
   logic [IDX_W-1:0]     l_idx;
   logic [MAX_TAG_W-1:0] l_tag;
   logic                 lm0, lm1, l_match;
   entry_t               l_entry;

   assign l_idx   = bus.lookup_tag[IDX_W-1:0];
   assign l_tag   = MAX_TAG_W'(bus.lookup_tag);
   assign lm0     = tbl_q[0][l_idx].valid && (tbl_q[0][l_idx].tag == l_tag);
   assign lm1     = tbl_q[1][l_idx].valid && (tbl_q[1][l_idx].tag == l_tag);
   assign l_match = lm0 | lm1;
   assign l_entry = lm0 ? tbl_q[0][l_idx] : tbl_q[1][l_idx];

`ifdef BPB_COUNTER_EN
   assign bus.hit = l_match & l_entry.ctr[1];
`else
   assign bus.hit = l_match;
`endif
   assign bus.pred_addr = bus.hit ? l_entry.target : 32'h0;

   // Controller-side write/confirm
   logic [IDX_W-1:0]     s_idx;
   logic [MAX_TAG_W-1:0] s_tag;
   logic                 sm0, sm1, s_match, s_way, targets_differ;
   entry_t               s_entry;

   assign s_idx          = bus.set_tag[IDX_W-1:0];
   assign s_tag          = MAX_TAG_W'(bus.set_tag);
   assign sm0            = tbl_q[0][s_idx].valid && (tbl_q[0][s_idx].tag == s_tag);
   assign sm1            = tbl_q[1][s_idx].valid && (tbl_q[1][s_idx].tag == s_tag);
   assign s_match        = sm0 | sm1;
   assign s_way          = sm0 ? 1'b0 : 1'b1;
   assign s_entry        = sm0 ? tbl_q[0][s_idx] : tbl_q[1][s_idx];
   assign targets_differ = s_entry.target != bus.check_addr;
   assign bus.conflict   = bus.sw & s_match & targets_differ;

`ifdef BPB_COUNTER_EN
   ctr_t ctr_next;

   bpb_sat_counter u_sat_counter (
      .ctr      (s_entry.ctr),
      .up       (~targets_differ),
      .ctr_next (ctr_next)
   );
`endif

   // Existing tag first, then an empty way (way0 first), then the LRU victim.
   logic alloc_way;

   always_comb begin
      alloc_way = 1'b0;
      if (sm0)                         alloc_way = 1'b0;
      else if (sm1)                    alloc_way = 1'b1;
      else if (!tbl_q[0][s_idx].valid) alloc_way = 1'b0;
      else if (!tbl_q[1][s_idx].valid) alloc_way = 1'b1;
      else                             alloc_way = lru_q[s_idx];
   end

   // Single write port: w_en takes priority and a concurrent sw is dropped.
   logic   wr_en, wr_way, lru_en;
   entry_t wr_entry;

   always_comb begin
      wr_en    = 1'b0;
      wr_way   = 1'b0;
      lru_en   = 1'b0;
      wr_entry = s_entry;
      if (!bus.stall) begin
         if (bus.w_en) begin
            wr_en    = 1'b1;
            wr_way   = alloc_way;
            lru_en   = 1'b1;
            wr_entry = '{valid:  bus.set_valid,
                         tag:    s_tag,
                         target: bus.set_addr,
                         ctr:    CTR_INIT};
         end else if (bus.sw && s_match) begin
            wr_way = s_way;
            lru_en = 1'b1;
`ifdef BPB_COUNTER_EN
            wr_en        = 1'b1;
            wr_entry.ctr = ctr_next;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < int'(SETS); s++) begin
               tbl_q[w][s] <= '0;
            end
         end
         lru_q <= '0;
      end else begin
         if (wr_en)  tbl_q[wr_way][s_idx] <= wr_entry;
         if (lru_en) lru_q[s_idx]         <= ~wr_way;
      end
   end

endmodule

// File: tb/tb_bpb_table.sv
// Directed vector bench for bpb_table: one vector per clock, outputs checked mid-cycle.
module tb_bpb_table;

`ifdef BPB_COUNTER_EN
   localparam bit CtrEn = 1'b1;
`else
   localparam bit CtrEn = 1'b0;
`endif

   localparam logic [31:0] A1 = 32'h0040_0040;
   localparam logic [31:0] A2 = 32'h0040_0180;
   localparam logic [31:0] A3 = 32'h0040_0080;
   localparam logic [31:0] A4 = 32'h0040_0100;
   localparam logic [31:0] A5 = 32'h0040_0300;

   typedef struct {
      logic        stall;
      logic        w_en;
      logic        sw;
      logic        set_valid;
      logic [29:0] set_tag;
      logic [31:0] set_addr;
      logic [31:0] check_addr;
      logic [29:0] lookup_tag;
      logic        exp_hit;
      logic [31:0] exp_pred;
      logic        exp_conf;
   } vec_t;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_pass;

   bpb_table_if #(.TAG_WIDTH(30)) bus ();

   bpb_table #(
      .ENTRIES   (16),
      .TAG_WIDTH (30)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic we, input logic s, input logic v,
                               input logic [29:0] tag, input logic [31:0] addr,
                               input logic [31:0] chk, input logic [29:0] lk,
                               input logic eh, input logic [31:0] ep, input logic ec);
      vec_t r;
      r.stall = st; r.w_en = we; r.sw = s; r.set_valid = v; r.set_tag = tag;
      r.set_addr = addr; r.check_addr = chk; r.lookup_tag = lk;
      r.exp_hit = eh; r.exp_pred = ep; r.exp_conf = ec;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic drive(input vec_t v);
      bus.stall      = v.stall;
      bus.w_en       = v.w_en;
      bus.sw         = v.sw;
      bus.set_valid  = v.set_valid;
      bus.set_tag    = v.set_tag;
      bus.set_addr   = v.set_addr;
      bus.check_addr = v.check_addr;
      bus.lookup_tag = v.lookup_tag;
   endtask

   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      #1;
      check({name, " hit"}, 32'(bus.hit), 32'(v.exp_hit));
      check({name, " pred_addr"}, bus.pred_addr, v.exp_pred);
      check({name, " conflict"}, 32'(bus.conflict), 32'(v.exp_conf));
   endtask

   vec_t vecs[$];
   vec_t lru_seq[$];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      resetn   = 1'b0;
      drive(mk(0, 0, 0, 0, 30'h0, 32'h0, 32'h0, 30'h10, 0, 32'h0, 0));

      //         st we sw v  tag      addr    check   lookup   hit         pred              conf
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 30'h10, A1,    32'h0, 30'h10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, 1, A1,    0));
      vecs.push_back(mk(0, 1, 0, 1, 30'h18, A2,    32'h0, 30'h10, 1, A1,    0));
      vecs.push_back(mk(0, 1, 0, 1, 30'h08, A3,    32'h0, 30'h18, 1, A2,    0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h18, 1, A2,    0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h08, 1, A3,    0));
      // Reinstall 0x10: evicts 0x18 (LRU points at way1 after 0x08 went to way0).
      vecs.push_back(mk(0, 1, 0, 1, 30'h10, A1,    32'h0, 30'h18, 1, A2,    0));
      vecs.push_back(mk(0, 0, 1, 0, 30'h10, 32'h0, A3,    30'h10, 1, A1,    1));
      vecs.push_back(mk(0, 0, 1, 0, 30'h10, 32'h0, A3,    30'h10, !CtrEn, CtrEn ? 32'h0 : A1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, !CtrEn, CtrEn ? 32'h0 : A1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 30'h10, 32'h0, A1,    30'h10, !CtrEn, CtrEn ? 32'h0 : A1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 30'h10, 32'h0, A1,    30'h10, !CtrEn, CtrEn ? 32'h0 : A1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, 1, A1,    0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h18, 32'h0, 32'h0, 30'h18, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 30'h30, 32'h0, 32'h1, 30'h08, 1, A3,    0));
      // w_en and sw together: write wins, conflict still reflects the old target.
      vecs.push_back(mk(0, 1, 1, 1, 30'h08, A4,    32'h0, 30'h08, 1, A3,    1));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h08, 1, A4,    0));
      vecs.push_back(mk(1, 1, 0, 1, 30'h20, A5,    32'h0, 30'h08, 1, A4,    0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h20, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 30'h08, 32'h0, 32'h0, 30'h08, 1, A4,    1));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h08, 1, A4,    0));
      vecs.push_back(mk(0, 1, 0, 0, 30'h08, 32'h0, 32'h0, 30'h08, 1, A4,    0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h08, 0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 30'h13, A5,    32'h0, 30'h13, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h13, 1, A5,    0));

      #2 resetn = 1'b1;
      foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

      // Asynchronous reset in the middle of a cycle clears outputs before the next edge.
      @(posedge clk);
      #1;
      drive(mk(0, 0, 1, 0, 30'h13, 32'h0, 32'h0, 30'h13, 0, 32'h0, 0));
      #1;
      check("pre-reset hit", 32'(bus.hit), 32'd1);
      check("pre-reset conflict", 32'(bus.conflict), 32'd1);
      resetn = 1'b0;
      #1;
      check("async reset hit", 32'(bus.hit), 32'd0);
      check("async reset pred_addr", bus.pred_addr, 32'h0);
      check("async reset conflict", 32'(bus.conflict), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      apply(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h13, 0, 32'h0, 0), "post-reset");

      // A confirm refreshes LRU: touching 0x10 last makes 0x18 the victim of 0x08.
      lru_seq.push_back(mk(0, 1, 0, 1, 30'h10, A1,    32'h0, 30'h10, 0, 32'h0, 0));
      lru_seq.push_back(mk(0, 1, 0, 1, 30'h18, A2,    32'h0, 30'h10, 1, A1,    0));
      lru_seq.push_back(mk(0, 0, 1, 0, 30'h18, 32'h0, A2,    30'h18, 1, A2,    0));
      lru_seq.push_back(mk(0, 0, 1, 0, 30'h10, 32'h0, A1,    30'h10, 1, A1,    0));
      lru_seq.push_back(mk(0, 1, 0, 1, 30'h08, A3,    32'h0, 30'h18, 1, A2,    0));
      lru_seq.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h10, 1, A1,    0));
      lru_seq.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h18, 0, 32'h0, 0));
      lru_seq.push_back(mk(0, 0, 0, 0, 30'h00, 32'h0, 32'h0, 30'h08, 1, A3,    0));
      foreach (lru_seq[i]) apply(lru_seq[i], $sformatf("lru%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
